spi_sat_slave: RTL and testbench
================================

// Module: spi_sat_slave
// PURPOSE
//  SPI mode-0 target (responder): the far end of the spi_sat master link. Oversamples
//  SCLK/CS_N/MOSI in the clk domain, shifts MOSI into an RX register, drives MISO MSB-first.
//  Each frame delivers received bits and bit count to local logic; sits on peripheral/test side.
// PARAMETERS
//  TX_LEN       1  bytes returned on MISO per frame (1..8)
//  RX_LEN       1  bytes captured from MOSI per frame (1..8)
//  SYNC_STAGES  2  synchronizer depth on SCLK/CS_N/MOSI (>=2)
// PORTS
//  clk          in   1          system clock
//  rst_n        in   1          asynchronous reset, active-low
//  tx_data      in   TX_LEN*8   response word; sampled at frame start
//  tx_busy      out  1          frame in progress; tx_data may change only when 0
//  rx_data      out  RX_LEN*8   last RX_LEN*8 bits received, right-aligned
//  rx_count     out  8          bits clocked in last frame (saturates at 255)
//  rx_valid     out  1          frame complete, data held until rx_ack
//  rx_ack       in   1          clears rx_valid
//  SPI_SCLK     in   1          serial clock from master (idle low)
//  SPI_CS_N     in   1          chip select, active-low
//  SPI_MOSI     in   1          master-out data
//  SPI_MISO     out  1          slave-out data
//  SPI_MISO_OE  out  1          MISO output enable (1 only while selected)
// BEHAVIOUR
//  - Reset: tx_busy=0, rx_data=0, rx_count=0, rx_valid=0, SPI_MISO=0, SPI_MISO_OE=0, state IDLE.
//    Synchronizers reset CS_N=1, SCLK=0, MOSI=0.
//  - Edge detect on synchronized SCLK/CS_N; detection latency SYNC_STAGES+1 clk.
//    Timing rule: SCLK half-period >= SYNC_STAGES+2 clk (spi_sat SCLK_DIV>=4 with default).
//  - FSM IDLE -> ACTIVE on CS_N fall, only if armed (CS_N seen high in IDLE since reset);
//    a reset mid-frame thus ignores the remainder of that frame.
//  - Entering ACTIVE: tx_shift<={tx_data,zeros}; bit_cnt<=0; tx_busy<=1; MISO_OE<=1; MISO=MSB.
//  - ACTIVE, SCLK rise: rx_shift<={rx_shift,MOSI}; bit_cnt<=sat(bit_cnt+1).
//  - ACTIVE, SCLK fall: tx_shift shifts left; bits beyond TX_LEN*8 are 0.
//  - ACTIVE -> IDLE on CS_N rise (same cycle as any SCLK edge: edge processed first):
//    rx_data<=rx_shift[RX_LEN*8-1:0]; rx_count<=bit_cnt; rx_valid<=1 iff bit_cnt!=0;
//    tx_busy<=0; MISO_OE<=0; MISO<=0. Short frames leave unfilled upper bits 0.
//  - Zero-clock frame (CS pulse without SCLK): no rx_valid, rx_data/rx_count unchanged.
//  - rx_ack clears rx_valid; rx_ack same cycle as frame end -> rx_valid=1 (new frame wins).
//  - Frame end with rx_valid already 1: data overwritten (see overrun option).
//  - SCLK edges while CS_N high are ignored.
// CONFIGURATION
//  SPI_SAT_SLAVE_OVERRUN_EN defined: adds output rx_overrun (1b, reset 0), set when a frame
//   completes while rx_valid=1 and not acked that cycle; sticky until rx_ack.
//  Undefined: port absent, overwrite silent.
// STRUCTURE
//  - spi_pkg: SPI_MAX_BYTES=8, spi_slv_state_e {IDLE,ACTIVE}, SPI_CNT_W=8.
//  - Sub-module spi_sync_edge (param STAGES, RST_VAL): sync + rise/fall pulses;
//    instanced for SCLK, CS_N; MOSI uses plain synchronizer of same depth.
// TESTING (bench: spi_sat master SCLK_DIV=4 looped to this block)
//  1. TX_LEN=RX_LEN=1: master cmd 0xA5, slave tx_data 0x3C -> rx_data=0xA5, rx_count=8,
//     rx_valid=1; master resp=0x3C.
//  2. RX_LEN=2, master tx_bits=12 cmd 0xABC -> rx_data=0x0ABC, rx_count=12.
//  3. TX_LEN=1, master 16-bit frame -> MISO bits 9..16 are 0; master resp low byte 0x00.
//  4. Two frames no rx_ack -> second data held; OVERRUN_EN: rx_overrun=1, cleared by rx_ack.
//  5. rx_ack asserted the cycle frame ends -> rx_valid stays 1 with new data.
//  6. rst_n pulsed after 4 bits -> outputs at reset values; rest of frame ignored;
//     next full frame 0x5A received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the spi_sat link target.
package spi_pkg;
  localparam int SPI_MAX_BYTES = 8;
  localparam int SPI_CNT_W     = 8;

  typedef enum logic {IDLE, ACTIVE} spi_slv_state_e;

  function automatic logic [SPI_CNT_W-1:0] sat_inc(input logic [SPI_CNT_W-1:0] v);
    return (&v) ? v : v + SPI_CNT_W'(1);
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer with single-cycle rise/fall pulses on the synced level.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;
endmodule

// File: rtl/spi_sat_slave.sv
// SPI mode-0 target: oversampled SCLK/CS_N/MOSI, MSB-first MISO, framed RX delivery.
// Optional SPI_SAT_SLAVE_OVERRUN_EN adds a sticky rx_overrun flag.
module spi_sat_slave
  import spi_pkg::*;
#(
  parameter int TX_LEN      = 1,
  parameter int RX_LEN      = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TX_LEN*8-1:0]  tx_data,
  output logic                 tx_busy,
  output logic [RX_LEN*8-1:0]  rx_data,
  output logic [SPI_CNT_W-1:0] rx_count,
  output logic                 rx_valid,
  input  logic                 rx_ack,
`ifdef SPI_SAT_SLAVE_OVERRUN_EN
  output logic                 rx_overrun,
`endif
  input  logic                 SPI_SCLK,
  input  logic                 SPI_CS_N,
  input  logic                 SPI_MOSI,
  output logic                 SPI_MISO,
  output logic                 SPI_MISO_OE
);
  localparam int TW = TX_LEN * 8;
  localparam int RW = RX_LEN * 8;

  spi_slv_state_e       state_q, state_d;
  logic                 armed_q, armed_d;
  logic [SYNC_STAGES-1:0] settle_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [TW-1:0]        tx_shift_q, tx_shift_d;
  logic [RW-1:0]        rx_shift_q, rx_shift_d;
  logic [SPI_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [RW-1:0]        rx_data_q, rx_data_d;
  logic [SPI_CNT_W-1:0] rx_count_q, rx_count_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_done;

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic mosi_q;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(SPI_SCLK),
    .q_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .d_i(SPI_CS_N),
    .q_o(cs_q), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  assign mosi_q = mosi_sync_q[SYNC_STAGES-1];

  // settle_q fills once the synchronizers hold real samples rather than reset values,
  // so a select that was already low across reset never arms the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync_q <= '0;
      settle_q    <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
      settle_q    <= {settle_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      bit_cnt_q  <= '0;
      rx_data_q  <= '0;
      rx_count_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_count_q <= rx_count_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    rx_data_d  = rx_data_q;
    rx_count_d = rx_count_q;
    rx_valid_d = rx_valid_q & ~rx_ack;
    frame_done = 1'b0;

    if (state_q == IDLE && (&settle_q) && cs_q) armed_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          state_d    = ACTIVE;
          tx_shift_d = tx_data;
          rx_shift_d = '0;
          bit_cnt_d  = '0;
        end
      end
      ACTIVE: begin
        if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[RW-2:0], mosi_q};
          bit_cnt_d  = sat_inc(bit_cnt_q);
        end
        if (sclk_fall) tx_shift_d = {tx_shift_q[TW-2:0], 1'b0};
        // Deselect closes the frame using the post-edge shift/count values.
        if (cs_rise) begin
          state_d    = IDLE;
          tx_shift_d = '0;
          if (bit_cnt_d != '0) begin
            rx_data_d  = rx_shift_d;
            rx_count_d = bit_cnt_d;
            rx_valid_d = 1'b1;
            frame_done = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SPI_SAT_SLAVE_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q & ~rx_ack;
    if (frame_done && rx_valid_q && !rx_ack) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun_q <= 1'b0;
    else        overrun_q <= overrun_d;
  end

  assign rx_overrun = overrun_q;
`endif

  assign tx_busy     = (state_q == ACTIVE);
  assign SPI_MISO_OE = (state_q == ACTIVE);
  assign SPI_MISO    = tx_shift_q[TW-1];
  assign rx_data     = rx_data_q;
  assign rx_count    = rx_count_q;
  assign rx_valid    = rx_valid_q;
endmodule

// File: tb/tb_spi_sat_slave.sv
// Bench for spi_sat_slave: behavioural SPI mode-0 master plus a frame-level reference model.
module tb_spi_sat_slave;
  localparam int TXL = 1;
  localparam int RXL = 2;
  localparam int SS  = 2;
  localparam int HP  = 6;

  logic                clk, rst_n;
  logic [TXL*8-1:0]    tx_data;
  logic                tx_busy;
  logic [RXL*8-1:0]    rx_data;
  logic [7:0]          rx_count;
  logic                rx_valid, rx_ack;
`ifdef SPI_SAT_SLAVE_OVERRUN_EN
  logic                rx_overrun;
`endif
  logic                sclk, cs_n, mosi, miso, miso_oe;

  spi_sat_slave #(.TX_LEN(TXL), .RX_LEN(RXL), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_count(rx_count), .rx_valid(rx_valid), .rx_ack(rx_ack),
`ifdef SPI_SAT_SLAVE_OVERRUN_EN
    .rx_overrun(rx_overrun),
`endif
    .SPI_SCLK(sclk), .SPI_CS_N(cs_n), .SPI_MOSI(mosi),
    .SPI_MISO(miso), .SPI_MISO_OE(miso_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mosi_bits[$];
  bit miso_bits[$];
  int oe_bad;

  // Frame-level reference state
  logic [15:0] m_data;
  logic [7:0]  m_count;
  bit          m_valid, m_ovr;

  function automatic logic [31:0] miso_exp(input logic [7:0] txd, input int n);
    logic [31:0] w = '0;
    for (int i = 0; i < n && i < 32; i++) w = {w[30:0], (i < 8) ? txd[7-i] : 1'b0};
    return w;
  endfunction

  function automatic logic [31:0] miso_got();
    logic [31:0] w = '0;
    for (int i = 0; i < miso_bits.size() && i < 32; i++) w = {w[30:0], miso_bits[i]};
    return w;
  endfunction

  task automatic load_bits(input logic [63:0] v, input int n);
    mosi_bits.delete();
    for (int i = n - 1; i >= 0; i--) mosi_bits.push_back(v[i]);
  endtask

  task automatic load_random(input int n);
    mosi_bits.delete();
    for (int i = 0; i < n; i++) mosi_bits.push_back(1'($urandom_range(1)));
  endtask

  // Runs one frame of mosi_bits.size()==nbits bits; optional rx_ack lands on the frame-end cycle.
  task automatic xfer(input int nbits, input logic [7:0] txd, input bit ack_at_end);
    miso_bits.delete();
    oe_bad = 0;
    tx_data = txd;
    @(negedge clk);
    cs_n = 1'b0;
    mosi = (nbits > 0) ? mosi_bits[0] : 1'b0;
    repeat (HP) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b1;
      if (!miso_oe || !tx_busy) oe_bad++;
      miso_bits.push_back(miso);
      repeat (HP) @(negedge clk);
      sclk = 1'b0;
      if (i + 1 < nbits) mosi = mosi_bits[i+1];
      repeat (HP) @(negedge clk);
    end
    cs_n = 1'b1;
    if (ack_at_end) begin
      repeat (SS) @(negedge clk);
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      repeat (HP) @(negedge clk);
    end else begin
      repeat (HP + SS) @(negedge clk);
    end
    if (ack_at_end) begin m_valid = 0; m_ovr = 0; end
    if (nbits > 0) begin
      if (m_valid) m_ovr = 1;
      m_valid = 1;
      m_count = (nbits > 255) ? 8'd255 : 8'(nbits);
      m_data  = '0;
      for (int i = (nbits > 16 ? nbits - 16 : 0); i < nbits; i++) m_data = {m_data[14:0], mosi_bits[i]};
    end
  endtask

  task automatic do_ack();
    @(negedge clk); rx_ack = 1'b1;
    @(negedge clk); rx_ack = 1'b0;
    @(negedge clk);
    m_valid = 0; m_ovr = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({tx_busy, rx_valid, miso, miso_oe} !== 4'b0) begin errors++;
      $display("FAIL reset_ctrl: got %b exp 0000", {tx_busy, rx_valid, miso, miso_oe}); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (rx_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h exp 0000", rx_data); end
    checks++; if (rx_count !== 8'h0) begin errors++; $display("FAIL reset_count: got %0d exp 0", rx_count); end
`ifdef SPI_SAT_SLAVE_OVERRUN_EN
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b exp 0", rx_overrun); end
`endif
    m_data = '0; m_count = '0; m_valid = 0; m_ovr = 0;
  endtask

  task automatic test_basic();
    load_bits(64'hA5, 8);
    xfer(8, 8'h3C, 1'b0);
    checks++; if (rx_data !== 16'h00A5) begin errors++; $display("FAIL basic_data: got %h exp 00a5", rx_data); end
    checks++; if (rx_count !== 8'd8) begin errors++; $display("FAIL basic_count: got %0d exp 8", rx_count); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b exp 1", rx_valid); end
    checks++; if (miso_got() !== 32'h3C) begin errors++; $display("FAIL basic_resp: got %h exp 3c", miso_got()); end
    checks++; if (oe_bad !== 0) begin errors++; $display("FAIL basic_oe_in_frame: got %0d bad samples exp 0", oe_bad); end
    checks++; if ({tx_busy, miso_oe, miso} !== 3'b000) begin errors++;
      $display("FAIL basic_idle_after: got %b exp 000", {tx_busy, miso_oe, miso}); end
    do_ack();
    checks++; if (rx_valid !== 1'b0 || rx_data !== 16'h00A5) begin errors++;
      $display("FAIL basic_ack: got valid %b data %h exp 0 00a5", rx_valid, rx_data); end
  endtask

  task automatic test_short_frame();
    load_bits(64'hABC, 12);
    xfer(12, 8'hC3, 1'b0);
    checks++; if (rx_data !== 16'h0ABC) begin errors++; $display("FAIL short_data: got %h exp 0abc", rx_data); end
    checks++; if (rx_count !== 8'd12) begin errors++; $display("FAIL short_count: got %0d exp 12", rx_count); end
    checks++; if (miso_got() !== miso_exp(8'hC3, 12)) begin errors++;
      $display("FAIL short_resp: got %h exp %h", miso_got(), miso_exp(8'hC3, 12)); end
    do_ack();
  endtask

  task automatic test_tx_pad();
    load_random(16);
    xfer(16, 8'h3C, 1'b0);
    checks++; if (miso_got() !== 32'h3C00) begin errors++; $display("FAIL txpad_resp: got %h exp 3c00", miso_got()); end
    checks++; if (rx_data !== m_data || rx_count !== 8'd16) begin errors++;
      $display("FAIL txpad_rx: got %h/%0d exp %h/16", rx_data, rx_count, m_data); end
    do_ack();
  endtask

  task automatic test_overrun();
    load_bits(64'h11, 8);
    xfer(8, 8'h00, 1'b0);
`ifdef SPI_SAT_SLAVE_OVERRUN_EN
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL ovr_first: got %b exp 0", rx_overrun); end
`endif
    load_bits(64'h2DE, 10);
    xfer(10, 8'hFF, 1'b0);
    checks++; if (rx_data !== m_data || rx_data !== 16'h02DE) begin errors++;
      $display("FAIL ovr_data: got %h exp %h", rx_data, m_data); end
    checks++; if (rx_valid !== 1'b1 || rx_count !== 8'd10) begin errors++;
      $display("FAIL ovr_valid_count: got %b/%0d exp 1/10", rx_valid, rx_count); end
`ifdef SPI_SAT_SLAVE_OVERRUN_EN
    checks++; if (rx_overrun !== m_ovr) begin errors++; $display("FAIL ovr_set: got %b exp %b", rx_overrun, m_ovr); end
`endif
    do_ack();
`ifdef SPI_SAT_SLAVE_OVERRUN_EN
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b exp 0", rx_overrun); end
`endif
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_ack: got %b exp 0", rx_valid); end
  endtask

  task automatic test_ack_same_cycle();
    load_bits(64'h77, 8);
    xfer(8, 8'h00, 1'b0);
    load_bits(64'h9C, 8);
    xfer(8, 8'h81, 1'b1);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ackcoll_valid: got %b exp 1", rx_valid); end
    checks++; if (rx_data !== 16'h009C) begin errors++; $display("FAIL ackcoll_data: got %h exp 009c", rx_data); end
`ifdef SPI_SAT_SLAVE_OVERRUN_EN
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL ackcoll_ovr: got %b exp 0", rx_overrun); end
`endif
    do_ack();
  endtask

  task automatic test_zero_clk_and_idle_sclk();
    for (int i = 0; i < 4; i++) begin
      sclk = 1'b1; repeat (HP) @(negedge clk);
      sclk = 1'b0; repeat (HP) @(negedge clk);
    end
    checks++; if (tx_busy !== 1'b0 || rx_valid !== 1'b0) begin errors++;
      $display("FAIL idle_sclk: got busy %b valid %b exp 0 0", tx_busy, rx_valid); end
    mosi_bits.delete();
    xfer(0, 8'h55, 1'b0);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL zeroclk_valid: got %b exp 0", rx_valid); end
    checks++; if (rx_data !== m_data || rx_count !== m_count) begin errors++;
      $display("FAIL zeroclk_hold: got %h/%0d exp %h/%0d", rx_data, rx_count, m_data, m_count); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] pat = 8'hC6;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (HP) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({tx_busy, rx_valid, miso, miso_oe, rx_count, rx_data} !== 28'h0) begin errors++;
          $display("FAIL midrst_outputs: got %h exp 0", {tx_busy, rx_valid, miso, miso_oe, rx_count, rx_data}); end
        rst_n = 1'b1;
        m_data = '0; m_count = '0; m_valid = 0; m_ovr = 0;
      end
      mosi = pat[7-i];
      sclk = 1'b1;
      if (i >= 4 && (tx_busy || miso_oe)) begin
        checks++; errors++;
        $display("FAIL midrst_ignored: got busy %b oe %b exp 0 0", tx_busy, miso_oe);
      end
      repeat (HP) @(negedge clk);
      sclk = 1'b0;
      repeat (HP) @(negedge clk);
    end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b exp 0", tx_busy); end
    cs_n = 1'b1;
    repeat (HP + SS) @(negedge clk);
    checks++; if (rx_valid !== 1'b0 || rx_count !== 8'd0) begin errors++;
      $display("FAIL midrst_tail: got %b/%0d exp 0/0", rx_valid, rx_count); end
    load_bits(64'h5A, 8);
    xfer(8, 8'hE1, 1'b0);
    checks++; if (rx_data !== 16'h005A || rx_valid !== 1'b1 || rx_count !== 8'd8) begin errors++;
      $display("FAIL midrst_next: got %h/%b/%0d exp 005a/1/8", rx_data, rx_valid, rx_count); end
    checks++; if (miso_got() !== 32'hE1) begin errors++; $display("FAIL midrst_resp: got %h exp e1", miso_got()); end
    do_ack();
  endtask

  task automatic test_random();
    for (int f = 0; f < 12; f++) begin
      int n = $urandom_range(24, 1);
      logic [7:0] txd = 8'($urandom);
      bit ack_end = ($urandom_range(3) == 0);
      load_random(n);
      xfer(n, txd, ack_end);
      checks++; if (rx_data !== m_data || rx_count !== m_count || rx_valid !== m_valid) begin errors++;
        $display("FAIL rand_%0d: got %h/%0d/%b exp %h/%0d/%b", f, rx_data, rx_count, rx_valid, m_data, m_count, m_valid); end
      checks++; if (miso_got() !== miso_exp(txd, n)) begin errors++;
        $display("FAIL rand_resp_%0d: got %h exp %h", f, miso_got(), miso_exp(txd, n)); end
`ifdef SPI_SAT_SLAVE_OVERRUN_EN
      checks++; if (rx_overrun !== m_ovr) begin errors++;
        $display("FAIL rand_ovr_%0d: got %b exp %b", f, rx_overrun, m_ovr); end
`endif
      if ($urandom_range(1) == 1) do_ack();
    end
    do_ack();
  endtask

  task automatic test_saturate();
    load_random(260);
    xfer(260, 8'h0F, 1'b0);
    checks++; if (rx_count !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d exp 255", rx_count); end
    checks++; if (rx_data !== m_data) begin errors++; $display("FAIL sat_data: got %h exp %h", rx_data, m_data); end
    do_ack();
  endtask

  initial begin
    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; rx_ack = 1'b0; tx_data = '0;
    test_reset();
    test_basic();
    test_short_frame();
    test_tx_pad();
    test_overrun();
    test_ack_same_cycle();
    test_zero_clk_and_idle_sclk();
    test_reset_mid_frame();
    test_random();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
